// File: rtl/prio_enc_arbiter.sv
// Eight requesters sharing one resource through a fixed-priority one-hot arbiter.
// Define PRIO_ENC_ARB_PREEMPT_EN for preemptive arbitration; default is non-preemptive.

module req_dev (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gen_req_i,
    input  logic       grant_i,
    input  logic [3:0] req_time_i,
    output logic       req_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gen_req_i) begin
                    state_d = PEND;
                    // A zero budget still needs one granted edge to release
                    cnt_d   = (req_time_i == 4'd0) ? 4'd1 : req_time_i;
                end
            end
            PEND: begin
                if (grant_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_o = (state_q == PEND);

endmodule

module prio_enc_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] grant_o
);

    logic [7:0] grant_q, grant_d;
    logic [7:0] lowest;

    // Isolate the lowest set request bit (bit 0 has top priority)
    assign lowest = req_i & (~req_i + 8'd1);

`ifdef PRIO_ENC_ARB_PREEMPT_EN
    always_comb begin
        grant_d = lowest;
    end
`else
    logic held;

    assign held = |(grant_q & req_i);

    always_comb begin
        grant_d = lowest;
        if (held) begin
            grant_d = grant_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 8'h00;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant_o = grant_q;

endmodule

module prio_enc_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] GEN_REQ,
    input  logic [3:0] REQ_TIME0,
    input  logic [3:0] REQ_TIME1,
    input  logic [3:0] REQ_TIME2,
    input  logic [3:0] REQ_TIME3,
    input  logic [3:0] REQ_TIME4,
    input  logic [3:0] REQ_TIME5,
    input  logic [3:0] REQ_TIME6,
    input  logic [3:0] REQ_TIME7,
    output logic [7:0] REQ,
    output logic [7:0] GRANT
);

    logic [3:0] req_time [8];

    assign req_time[0] = REQ_TIME0;
    assign req_time[1] = REQ_TIME1;
    assign req_time[2] = REQ_TIME2;
    assign req_time[3] = REQ_TIME3;
    assign req_time[4] = REQ_TIME4;
    assign req_time[5] = REQ_TIME5;
    assign req_time[6] = REQ_TIME6;
    assign req_time[7] = REQ_TIME7;

    for (genvar n = 0; n < 8; n++) begin : g_dev
        req_dev u_dev (
            .clk        (CLK),
            .rst_n      (RESET),
            .gen_req_i  (GEN_REQ[n]),
            .grant_i    (GRANT[n]),
            .req_time_i (req_time[n]),
            .req_o      (REQ[n])
        );
    end

    prio_enc_arb u_arb (
        .clk     (CLK),
        .rst_n   (RESET),
        .req_i   (REQ),
        .grant_o (GRANT)
    );

endmodule

// File: tb/tb_prio_enc_arbiter.sv
// Randomized and directed bench for prio_enc_arbiter against a queue-free
// behavioural model of the requesters and the priority arbiter.

module tb_prio_enc_arbiter;

`ifdef PRIO_ENC_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] GEN_REQ = 8'h00;
    logic [3:0] rt [8];
    logic [7:0] REQ;
    logic [7:0] GRANT;

    int errors = 0;
    int checks = 0;

    bit pend [8];
    int cnt  [8];
    int gidx = -1;

    always #5 CLK = ~CLK;

    prio_enc_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .GEN_REQ   (GEN_REQ),
        .REQ_TIME0 (rt[0]),
        .REQ_TIME1 (rt[1]),
        .REQ_TIME2 (rt[2]),
        .REQ_TIME3 (rt[3]),
        .REQ_TIME4 (rt[4]),
        .REQ_TIME5 (rt[5]),
        .REQ_TIME6 (rt[6]),
        .REQ_TIME7 (rt[7]),
        .REQ       (REQ),
        .GRANT     (GRANT)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) begin
            pend[i] = 1'b0;
            cnt[i]  = 0;
        end
        gidx = -1;
    endfunction

    function automatic logic [7:0] m_req();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = pend[i];
        return r;
    endfunction

    function automatic logic [7:0] m_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (gidx >= 0) g[gidx] = 1'b1;
        return g;
    endfunction

    // One rising edge of the whole subsystem, using pre-edge state
    function automatic void m_step();
        int first;
        int ng;
        if (!RESET) begin
            m_clear();
            return;
        end
        first = -1;
        for (int i = 7; i >= 0; i--) if (pend[i]) first = i;
        if (PREEMPT || gidx < 0 || !pend[gidx]) ng = first;
        else ng = gidx;
        for (int n = 0; n < 8; n++) begin
            if (!pend[n]) begin
                if (GEN_REQ[n]) begin
                    pend[n] = 1'b1;
                    cnt[n]  = (rt[n] == 4'd0) ? 1 : int'(rt[n]);
                end
            end else if (gidx == n) begin
                if (cnt[n] == 1) pend[n] = 1'b0;
                cnt[n] = cnt[n] - 1;
            end
        end
        gidx = ng;
    endfunction

    task automatic cyc(input logic [7:0] g);
        GEN_REQ = g;
        @(posedge CLK);
        m_step();
        @(negedge CLK);
        check("REQ", REQ, m_req());
        check("GRANT", GRANT, m_gnt());
    endtask

    task automatic set_rt(input logic [3:0] v);
        for (int i = 0; i < 8; i++) rt[i] = v;
    endtask

    int n5;
    int n0;
    int nany;
    bit found;

    initial begin
        m_clear();
        set_rt(4'd2);

        // Reset held with all requests asserted
        repeat (4) cyc(8'hFF);
        RESET = 1'b1;
        cyc(8'hFF);
        check("rst_req_up", REQ, 8'hFF);
        cyc(8'h00);
        check("first_grant", GRANT, 8'h01);
        repeat (30) cyc(8'h00);
        check("rst_drain", REQ | GRANT, 8'h00);

        // Single channel, budget 4
        rt[3] = 4'd4;
        nany = 0;
        cyc(8'h08);
        repeat (12) begin
            cyc(8'h00);
            if (GRANT == 8'h08) nany++;
        end
        check("ch3_len", 8'(nany), 8'd5);

        // All channels, budget 2: 8 grants of 3 cycles, no gaps
        set_rt(4'd2);
        nany = 0;
        cyc(8'hFF);
        repeat (30) begin
            cyc(8'h00);
            if (GRANT != 8'h00) nany++;
        end
        check("all_len", 8'(nany), 8'd24);

        // Channel 5 holds, channel 0 arrives mid-grant
        rt[5] = 4'd6;
        rt[0] = 4'd1;
        n5 = 0;
        n0 = 0;
        cyc(8'h20);
        repeat (3) begin
            cyc(8'h00);
            if (GRANT == 8'h20) n5++;
        end
        cyc(8'h01);
        if (GRANT == 8'h20) n5++;
        repeat (15) begin
            cyc(8'h00);
            if (GRANT == 8'h20) n5++;
            if (GRANT == 8'h01) n0++;
        end
        check("ch5_len", 8'(n5), 8'd7);
        check("ch0_len", 8'(n0), 8'd2);

        // Zero budget acts as one
        rt[6] = 4'd0;
        nany = 0;
        cyc(8'h40);
        repeat (8) begin
            cyc(8'h00);
            if (GRANT == 8'h40) nany++;
        end
        check("ch6_len", 8'(nany), 8'd2);

        // Asynchronous reset while channel 2 holds the grant
        set_rt(4'd3);
        found = 1'b0;
        cyc(8'h07);
        for (int i = 0; i < 40 && !found; i++) begin
            if (GRANT == 8'h04) found = 1'b1;
            else cyc(8'h00);
        end
        if (!found) check("wait_g04", GRANT, 8'h04);
        #2;
        RESET = 1'b0;
        #1;
        m_clear();
        check("async_req", REQ, 8'h00);
        check("async_gnt", GRANT, 8'h00);
        repeat (2) cyc(8'h07);
        RESET = 1'b1;
        repeat (3) cyc(8'h00);

        // Randomized traffic
        repeat (400) begin
            for (int i = 0; i < 8; i++) rt[i] = 4'($urandom_range(0, 15));
            cyc(8'($urandom & $urandom & $urandom));
        end
        repeat (140) cyc(8'h00);
        check("rand_drain", REQ | GRANT, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
